iob_clock_div: RTL and testbench

IOB_CLOCK_DIV -- requirements
Module: iob_clock_div

---
 rtl/iob_clock_div.sv | 67 ++++++
 tb/tb_iob_clock_div.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_clock_div.sv
// rtl/iob_clock_div.sv - multi-channel programmable clock divider with registered clock and tick outputs
module iob_clock_div #(
    parameter int N_CH  = 2,
    parameter int DIV_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cke_i,
    input  logic                    sync_i,
    input  logic [N_CH-1:0]         en_i,
    input  logic [N_CH*DIV_W-1:0]   div_i,
    output logic [N_CH-1:0]         clk_o,
    output logic [N_CH-1:0]         tick_o
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] dq;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] div_c;
        logic [DIV_W-1:0] last;
        logic             run;
        logic             clk_q;
        logic             tick_q;

        always_comb begin
            div   = div_i[k*DIV_W +: DIV_W];
            div_c = (div < MIN_DIV) ? MIN_DIV : div;
            last  = dq - ONE;
            run   = en_i[k] & ~sync_i;
        end

        // dq is only reloaded at a wrap or while stopped, so a ratio change
        // never alters the period already in progress.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt    <= '0;
                dq     <= MIN_DIV;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (cke_i) begin
                if (!run) begin
                    cnt    <= '0;
                    dq     <= div_c;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    clk_q  <= (cnt < (dq >> 1));
                    tick_q <= (cnt == last);
                    if (cnt == last) begin
                        cnt <= '0;
                        dq  <= div_c;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            end
        end

        assign clk_o[k]  = clk_q;
        assign tick_o[k] = tick_q;
    end

endmodule

// File: tb/tb_iob_clock_div.sv
// tb/tb_iob_clock_div.sv - self-checking bench for iob_clock_div against a phase/period model
module tb_iob_clock_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        sync;
    logic [1:0]  en;
    logic [15:0] div;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;
    logic        en4;
    logic [3:0]  div4;
    logic        clk4;
    logic        tick4;

    int n_checks = 0;
    int n_fail   = 0;

    int   m_ph   [3];
    int   m_per  [3];
    logic m_clk  [3];
    logic m_tick [3];

    iob_clock_div #(.N_CH(2), .DIV_W(8)) u_dut (
        .clk_i (clk), .rst_i (rst), .cke_i (cke), .sync_i (sync),
        .en_i (en), .div_i (div), .clk_o (clk_o), .tick_o (tick_o)
    );

    iob_clock_div #(.N_CH(1), .DIV_W(4)) u_dut4 (
        .clk_i (clk), .rst_i (rst), .cke_i (cke), .sync_i (sync),
        .en_i (en4), .div_i (div4), .clk_o (clk4), .tick_o (tick4)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Channel view: phase within a period of length per; high for the first per/2 phases.
    task automatic model_step();
        logic e [3];
        int   d [3];
        e[0] = en[0]; e[1] = en[1]; e[2] = en4;
        d[0] = int'(div[7:0]); d[1] = int'(div[15:8]); d[2] = int'(div4);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_ph[k] = 0; m_per[k] = 2; m_clk[k] = 1'b0; m_tick[k] = 1'b0;
            end else if (cke) begin
                if (!e[k] || sync) begin
                    m_ph[k] = 0; m_per[k] = clampd(d[k]); m_clk[k] = 1'b0; m_tick[k] = 1'b0;
                end else begin
                    m_clk[k]  = (m_ph[k] < m_per[k] / 2);
                    m_tick[k] = (m_ph[k] == m_per[k] - 1);
                    m_ph[k]   = (m_ph[k] + 1) % m_per[k];
                    if (m_ph[k] == 0) m_per[k] = clampd(d[k]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic start(input logic [1:0] e);
        en = 2'b00;
        tick();
        en = e;
    endtask

    task automatic test_reset();
        rst = 1'b1; cke = 1'b1; sync = 1'b0; en = 2'b11; div = 16'h0504;
        en4 = 1'b1; div4 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({clk_o, tick_o, clk4, tick4} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got clk=%b tick=%b clk4=%b tick4=%b expected all 0",
                         i, clk_o, tick_o, clk4, tick4);
            end
        end
        rst = 1'b0; en4 = 1'b0;
    endtask

    task automatic test_basic();
        div = {8'd5, 8'd4};
        start(2'b11);
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (clk_o !== {1'((i % 5) < 2), 1'((i % 4) < 2)} ||
                tick_o !== {1'((i % 5) == 4), 1'((i % 4) == 3)}) begin
                n_fail++;
                $display("FAIL basic_d4_d5 i=%0d: got clk=%b tick=%b expected clk=%b tick=%b", i, clk_o, tick_o,
                         {1'((i % 5) < 2), 1'((i % 4) < 2)}, {1'((i % 5) == 4), 1'((i % 4) == 3)});
            end
        end
    endtask

    task automatic test_small_div();
        div = {8'd1, 8'd0};
        start(2'b11);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (clk_o !== {2{1'(i % 2 == 0)}} || tick_o !== {2{1'(i % 2 == 1)}}) begin
                n_fail++;
                $display("FAIL small_div i=%0d: got clk=%b tick=%b expected clk=%b tick=%b", i, clk_o, tick_o,
                         {2{1'(i % 2 == 0)}}, {2{1'(i % 2 == 1)}});
            end
        end
    endtask

    task automatic test_div_change();
        logic ec;
        logic et;
        div = {8'd2, 8'd6};
        start(2'b01);
        for (int i = 0; i < 15; i++) begin
            if (i == 2) div[7:0] = 8'd3;
            tick();
            ec = (i < 6) ? (i < 3) : (((i - 6) % 3) < 1);
            et = (i < 6) ? (i == 5) : (((i - 6) % 3) == 2);
            n_checks++;
            if (clk_o[0] !== ec || tick_o[0] !== et) begin
                n_fail++;
                $display("FAIL div_change i=%0d: got clk=%b tick=%b expected clk=%b tick=%b", i, clk_o[0], tick_o[0], ec, et);
            end
        end
    endtask

    task automatic test_sync();
        div = {8'd6, 8'd4};
        start(2'b11);
        repeat (7) tick();
        sync = 1'b1;
        tick();
        n_checks++;
        if (clk_o !== 2'b00 || tick_o !== 2'b00) begin
            n_fail++;
            $display("FAIL sync_stop: got clk=%b tick=%b expected clk=00 tick=00", clk_o, tick_o);
        end
        sync = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (clk_o !== {1'((i % 6) < 3), 1'((i % 4) < 2)}) begin
                n_fail++;
                $display("FAIL sync_align i=%0d: got clk=%b expected %b", i, clk_o, {1'((i % 6) < 3), 1'((i % 4) < 2)});
            end
        end
    endtask

    task automatic test_cke();
        div = {8'd5, 8'd8};
        start(2'b11);
        tick();
        tick();
        cke = 1'b0; sync = 1'b1; en = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (clk_o !== 2'b11 || tick_o !== 2'b00) begin
                n_fail++;
                $display("FAIL cke_freeze cycle %0d: got clk=%b tick=%b expected clk=11 tick=00", i, clk_o, tick_o);
            end
        end
        cke = 1'b1; sync = 1'b0; en = 2'b11;
        for (int i = 2; i < 18; i++) begin
            tick();
            n_checks++;
            if (clk_o !== {1'((i % 5) < 2), 1'((i % 8) < 4)} ||
                tick_o !== {1'((i % 5) == 4), 1'((i % 8) == 7)}) begin
                n_fail++;
                $display("FAIL cke_resume i=%0d: got clk=%b tick=%b expected clk=%b tick=%b", i, clk_o, tick_o,
                         {1'((i % 5) < 2), 1'((i % 8) < 4)}, {1'((i % 5) == 4), 1'((i % 8) == 7)});
            end
        end
    endtask

    task automatic test_reset_mid();
        div = {8'd4, 8'd8};
        start(2'b11);
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (clk_o !== 2'b00 || tick_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got clk=%b tick=%b expected clk=00 tick=00", i, clk_o, tick_o);
            end
        end
        rst = 1'b0;
        start(2'b11);
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (clk_o !== {1'((i % 4) < 2), 1'((i % 8) < 4)}) begin
                n_fail++;
                $display("FAIL reset_restart i=%0d: got clk=%b expected %b", i, clk_o, {1'((i % 4) < 2), 1'((i % 8) < 4)});
            end
        end
    endtask

    task automatic test_div15();
        int highs;
        highs = 0;
        en = 2'b00;
        div4 = 4'd15;
        en4 = 1'b0;
        tick();
        en4 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i < 15 && clk4 === 1'b1) highs++;
            n_checks++;
            if (clk4 !== 1'((i % 15) < 7) || tick4 !== 1'((i % 15) == 14)) begin
                n_fail++;
                $display("FAIL div15 i=%0d: got clk=%b tick=%b expected clk=%b tick=%b", i, clk4, tick4,
                         1'((i % 15) < 7), 1'((i % 15) == 14));
            end
        end
        n_checks++;
        if (highs != 7) begin
            n_fail++;
            $display("FAIL div15_high_count: got %0d expected 7", highs);
        end
        en4 = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            cke  = ($urandom_range(0, 7) != 0);
            sync = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) en = 2'($urandom);
            if ($urandom_range(0, 15) == 0) en4 = 1'($urandom);
            if ($urandom_range(0, 9) == 0) div[7:0]  = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) div[15:8] = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) div4 = 4'($urandom);
            tick();
            n_checks++;
            if (clk_o !== {m_clk[1], m_clk[0]} || tick_o !== {m_tick[1], m_tick[0]} ||
                clk4 !== m_clk[2] || tick4 !== m_tick[2]) begin
                n_fail++;
                $display("FAIL random i=%0d: got clk=%b tick=%b clk4=%b tick4=%b expected clk=%b tick=%b clk4=%b tick4=%b",
                         i, clk_o, tick_o, clk4, tick4, {m_clk[1], m_clk[0]}, {m_tick[1], m_tick[0]}, m_clk[2], m_tick[2]);
            end
        end
        rst = 1'b0; cke = 1'b1; sync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_div();
        test_div_change();
        test_sync();
        test_cke();
        test_reset_mid();
        test_div15();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
